// File: rtl/rf_savestate_ctrl.sv
`default_nettype none
// ============================================================================
//  Module     : rf_savestate_ctrl
//  Description: Save/restore sequencer for the 8x16 register file.
//               It drives the register file's read and write ports from the
//               opposite side to the normal datapath.
//               A save reads r0..r(NREGS-1) in order through one read port.
//               It then streams those words out on a valid/ready port.
//               A restore accepts NREGS words on a valid/ready input stream.
//               It writes them to r0..r(NREGS-1) in order.
//  Revision   : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   clock, rising edge
//    rst_n        in   asynchronous active-low reset
//    save_req     in   1-cycle request to start a save
//    restore_req  in   1-cycle request to start a restore
//    busy         out  high while an operation is in progress (state != IDLE)
//    done         out  1-cycle pulse in the final cycle of an operation
//    err          out  1-cycle pulse, the cycle after a rejected request
//    rf_readsel   out  rf read select (read data returns combinationally)
//    rf_readdata  in   rf read data for rf_readsel
//    rf_writesel  out  rf write select (registered)
//    rf_writedata out  rf write data (registered)
//    rf_write     out  rf write enable (registered, 1-cycle pulse per word)
//    sout_*       out  save stream (data/valid out, ready in)
//    sin_*        in   restore stream (data/valid in, ready out)
// ============================================================================
module rf_savestate_ctrl #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  parameter int SELW  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             save_req,
  input  logic             restore_req,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [SELW-1:0]  rf_readsel,
  input  logic [WIDTH-1:0] rf_readdata,
  output logic [SELW-1:0]  rf_writesel,
  output logic [WIDTH-1:0] rf_writedata,
  output logic             rf_write,
  output logic [WIDTH-1:0] sout_data,
  output logic             sout_valid,
  input  logic             sout_ready,
  input  logic [WIDTH-1:0] sin_data,
  input  logic             sin_valid,
  output logic             sin_ready
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SV_LOAD = 3'd1,
    S_SV_SEND = 3'd2,
    S_RESTORE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [SELW-1:0] C_LAST_IDX = SELW'(NREGS - 1);
  localparam logic [SELW-1:0] C_IDX_ONE  = SELW'(1);

  // Registered state
  state_t           r_state;
  logic [SELW-1:0]  r_idx;
  logic [WIDTH-1:0] r_sout_data;
  logic             r_sout_valid;
  logic [SELW-1:0]  r_wr_sel;
  logic [WIDTH-1:0] r_wr_data;
  logic             r_wr;
  logic             r_err;

  // Next-state values
  state_t           w_state_n;
  logic [SELW-1:0]  w_idx_n;
  logic [WIDTH-1:0] w_sout_data_n;
  logic             w_sout_valid_n;
  logic [SELW-1:0]  w_wr_sel_n;
  logic [WIDTH-1:0] w_wr_data_n;
  logic             w_wr_n;
  logic             w_err_n;

  logic             w_idx_last;
  logic             w_sin_ready;

  assign w_idx_last  = (r_idx == C_LAST_IDX);
  assign w_sin_ready = (r_state == S_RESTORE);

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_sout_data  <= '0;
      r_sout_valid <= 1'b0;
      r_wr_sel     <= '0;
      r_wr_data    <= '0;
      r_wr         <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_idx        <= w_idx_n;
      r_sout_data  <= w_sout_data_n;
      r_sout_valid <= w_sout_valid_n;
      r_wr_sel     <= w_wr_sel_n;
      r_wr_data    <= w_wr_data_n;
      r_wr         <= w_wr_n;
      r_err        <= w_err_n;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and datapath logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_n      = r_state;
    w_idx_n        = r_idx;
    w_sout_data_n  = r_sout_data;
    w_sout_valid_n = r_sout_valid;
    w_wr_sel_n     = r_wr_sel;
    w_wr_data_n    = r_wr_data;
    w_wr_n         = 1'b0;
    w_err_n        = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (save_req && restore_req) begin
          // Ambiguous request: reject both and stay idle.
          w_err_n = 1'b1;
        end else if (save_req) begin
          w_state_n = S_SV_LOAD;
          w_idx_n   = '0;
        end else if (restore_req) begin
          w_state_n = S_RESTORE;
          w_idx_n   = '0;
        end
      end

      S_SV_LOAD: begin
        // rf_readsel is presented this cycle; capture the word into the
        // output holding register so it stays stable under backpressure.
        w_sout_data_n  = rf_readdata;
        w_sout_valid_n = 1'b1;
        w_state_n      = S_SV_SEND;
      end

      S_SV_SEND: begin
        if (r_sout_valid && sout_ready) begin
          w_sout_valid_n = 1'b0;
          if (w_idx_last) begin
            w_state_n = S_DONE;
          end else begin
            w_idx_n   = r_idx + C_IDX_ONE;
            w_state_n = S_SV_LOAD;
          end
        end
      end

      S_RESTORE: begin
        if (sin_valid && w_sin_ready) begin
          w_wr_n      = 1'b1;
          w_wr_sel_n  = r_idx;
          w_wr_data_n = sin_data;
          if (w_idx_last) begin
            // The write for the last word lands in the DONE cycle.
            w_state_n = S_DONE;
          end else begin
            w_idx_n = r_idx + C_IDX_ONE;
          end
        end
      end

      S_DONE: begin
        w_state_n = S_IDLE;
        w_idx_n   = '0;
      end

      default: begin
        w_state_n = S_IDLE;
        w_idx_n   = '0;
      end
    endcase

    // Requests outside IDLE (including the DONE cycle) are rejected and
    // never disturb the running operation.
    if ((r_state != S_IDLE) && (save_req || restore_req)) begin
      w_err_n = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // Read select is only driven while loading; it is zero elsewhere so that
  // it reads as 0 out of reset.
  assign rf_readsel   = (r_state == S_SV_LOAD) ? r_idx : '0;
  assign rf_writesel  = r_wr_sel;
  assign rf_writedata = r_wr_data;
  assign rf_write     = r_wr;
  assign sout_data    = r_sout_data;
  assign sout_valid   = r_sout_valid;
  assign sin_ready    = w_sin_ready;
  assign busy         = (r_state != S_IDLE);
  assign done         = (r_state == S_DONE);
  assign err          = r_err;

endmodule
`default_nettype wire
